mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-client line-fill arbiter between the instruction cache, the data cache and the single external line bus that feeds the flash ROM.
- Grants one outstanding fill at a time, round-robin on conflict.
- Registers the returned 512-bit line and hands it to the winning cache.
- A watchdog timer converts a hung fill into an error completion.

Parameters:
- ADDR_W, 32, byte address width
- LINE_W, 512, cache line width in bits (64 bytes)
- OFFSET_BITS, 6, log2(LINE_W/8); forced to zero in the outgoing address
- TIMEOUT, 255, cycles in REQ without mem_data_ready before an error completion (1..255)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- i_addr_valid  in  1  I-cache fill request; held until i_data_ready
- i_addr  in  ADDR_W  I-cache miss address; stable while i_addr_valid
- i_data_ready  out  1  one-cycle completion pulse to the I-cache
- i_data  out  LINE_W  returned line; valid while i_data_ready
- i_err  out  1  completion was a timeout; qualified by i_data_ready
- d_addr_valid, d_addr, d_data_ready, d_data, d_err: same as the i_* ports, for the D-cache
- mem_addr_valid  out  1  external bus request
- mem_addr  out  ADDR_W  line-aligned address
- mem_data_ready  in  1  slave line valid; may be combinational on mem_addr_valid
- mem_data_i  in  LINE_W  slave line data

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, last_grant=D, timeout counter=0.
  - Line buffer cleared to 0.
  - All outputs 0.
  - Any in-flight fill is dropped; clients reissue after reset release.
- States: IDLE, REQ, RESP.
- IDLE:
  - Sample i_addr_valid and d_addr_valid.
  - Exactly one asserted: grant it.
  - Both asserted: grant the client that is not last_grant, so I wins the first conflict after reset.
  - On grant: latch {addr[ADDR_W-1:OFFSET_BITS], OFFSET_BITS'b0} into mem_addr, set owner and last_grant=owner, clear the counter, go to REQ.
- REQ:
  - mem_addr_valid=1 with stable mem_addr.
  - Edge with mem_data_ready=1: capture mem_data_i into the line buffer, err=0, go to RESP.
  - Otherwise increment the counter. If the counter reaches TIMEOUT-1 without ready: buffer=0, err=1, go to RESP.
- RESP:
  - mem_addr_valid=0.
  - Owner's *_data_ready=1 for exactly one cycle; *_data = buffer and *_err = err for the owner.
  - Go to IDLE.
- Non-owner outputs are 0 in every state.
- Client rule: deassert *_addr_valid in the cycle after *_data_ready. Back-to-back requests are re-sampled in IDLE.
- Latency:
  - Request seen in IDLE cycle N → mem_addr_valid in N+1.
  - Combinational slave → *_data_ready in N+2.
  - Each slave wait cycle adds 1.
- Throughput: one fill per 3 cycles minimum; the IDLE cycle is a mandatory bus turnaround.
- Fairness:
  - With both clients continuously requesting, grants strictly alternate I,D,I,D.
  - A single requester is never blocked by last_grant.
- Requests arriving during REQ/RESP wait; they are not lost while the client holds valid.
- mem_data_ready in IDLE or RESP is ignored.
- Address offset bits are ignored: 0x0000_1234 fetches line 0x0000_1200.
- Timeout on the last counter value and mem_data_ready on the same edge: data wins, err=0.
- Reset asserted in REQ: mem_addr_valid drops immediately (async); no completion is issued.

Decomposition:
- Shared package holds:
  - LINE_W and OFFSET_BITS.
  - The arbiter state enum {IDLE, REQ, RESP}.
  - An owner enum {OWN_I, OWN_D}.
- Round-robin pick logic is small enough to stay inline.
- Optional sub-module mem_arb_watchdog: counter with clear/enable/expired, parameterised by TIMEOUT.

Test Plan:
- I-only request at addr 0x0000_0044, slave ready combinational with line pattern A5A5… → mem_addr=0x0000_0040 one cycle after request; i_data_ready=1 for one cycle two cycles after request; i_data=pattern; i_err=0; d_* stay 0.
- I and D both raise valid in the same cycle (I=0x100, D=0x2000) → first mem_addr=0x100 (I served); D waits; next grant mem_addr=0x2000; two completions, no overlap.
- Both clients request continuously for 8 fills → grant order I,D,I,D,I,D,I,D; fill spacing is exactly 3 cycles with a zero-wait slave.
- Slave inserts 4 wait cycles on a D fill → mem_addr_valid held 5 cycles with stable address; d_data_ready 6 cycles after request.
- Slave never responds (TIMEOUT=16) → d_data_ready pulses after 16 REQ cycles with d_err=1 and d_data=0; the next I request is served normally.
- rst pulled low for 1 cycle during REQ → mem_addr_valid and all outputs go to 0 asynchronously; after release, the held request is re-granted from IDLE and completes normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D line-fill arbiter.
// Line geometry plus FSM and ownership encodings.
package mem_arbiter_pkg;

   localparam int LINE_W      = 512;
   localparam int OFFSET_BITS = 6;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RESP
   } state_t;

   typedef enum logic {
      OWN_I,
      OWN_D
   } owner_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Fill watchdog: counts stalled REQ cycles and flags the final one.
// Held clear outside REQ so every fill starts from zero.
module mem_arb_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

   logic [7:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + 8'd1;
      end
   end

   assign expired = (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin line-fill arbiter between I-cache, D-cache and the line bus.
// One fill in flight; an idle cycle separates fills as bus turnaround.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_addr_valid,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_data_ready,
   output logic [LINE_W-1:0] i_data,
   output logic              i_err,
   input  logic              d_addr_valid,
   input  logic [ADDR_W-1:0] d_addr,
   output logic              d_data_ready,
   output logic [LINE_W-1:0] d_data,
   output logic              d_err,
   output logic              mem_addr_valid,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_data_ready,
   input  logic [LINE_W-1:0] mem_data_i
);

   state_t            state;
   owner_t            owner;
   owner_t            last_grant;
   owner_t            pick;
   logic [ADDR_W-1:0] line_addr;
   logic [LINE_W-1:0] line_q;
   logic              expired;
   logic              wd_clr;
   logic              wd_en;
   logic              unused_ofs;

   assign unused_ofs = ^{i_addr[OFFSET_BITS-1:0], d_addr[OFFSET_BITS-1:0]};

   assign wd_clr = (state != REQ);
   assign wd_en  = (state == REQ) && !mem_data_ready;

   mem_arb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wd (
      .clk     (clk),
      .rst     (rst),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (expired)
   );

   // On conflict the client that did not win last time goes first
   always_comb begin
      pick = OWN_D;
      if (i_addr_valid && d_addr_valid) begin
         pick = (last_grant == OWN_I) ? OWN_D : OWN_I;
      end else if (i_addr_valid) begin
         pick = OWN_I;
      end
      line_addr = {d_addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
      if (pick == OWN_I) begin
         line_addr = {i_addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         owner          <= OWN_I;
         last_grant     <= OWN_D;
         line_q         <= '0;
         mem_addr_valid <= 1'b0;
         mem_addr       <= '0;
         i_data_ready   <= 1'b0;
         d_data_ready   <= 1'b0;
         i_err          <= 1'b0;
         d_err          <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (i_addr_valid || d_addr_valid) begin
                  mem_addr       <= line_addr;
                  owner          <= pick;
                  last_grant     <= pick;
                  mem_addr_valid <= 1'b1;
                  state          <= REQ;
               end
            end
            REQ: begin
               // Data on the final watchdog cycle still counts as success
               if (mem_data_ready || expired) begin
                  line_q         <= mem_data_ready ? mem_data_i : '0;
                  mem_addr_valid <= 1'b0;
                  i_data_ready   <= (owner == OWN_I);
                  d_data_ready   <= (owner == OWN_D);
                  i_err          <= (owner == OWN_I) && !mem_data_ready;
                  d_err          <= (owner == OWN_D) && !mem_data_ready;
                  state          <= RESP;
               end
            end
            RESP: begin
               i_data_ready <= 1'b0;
               d_data_ready <= 1'b0;
               i_err        <= 1'b0;
               d_err        <= 1'b0;
               state        <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign i_data = i_data_ready ? line_q : '0;
   assign d_data = d_data_ready ? line_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small wait-state slave model.
// Drives and samples on the falling edge, away from the active edge.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int AW = 32;

   logic          clk;
   logic          rst;
   logic          i_addr_valid;
   logic [AW-1:0] i_addr;
   logic          i_data_ready;
   logic [LINE_W-1:0] i_data;
   logic          i_err;
   logic          d_addr_valid;
   logic [AW-1:0] d_addr;
   logic          d_data_ready;
   logic [LINE_W-1:0] d_data;
   logic          d_err;
   logic          mem_addr_valid;
   logic [AW-1:0] mem_addr;
   logic          mem_data_ready;
   logic [LINE_W-1:0] line_pat;

   logic slave_on;
   int   slave_wait;
   int   waited;
   int   pass_cnt;
   int   total_cnt;

   mem_arbiter #(
      .ADDR_W  (AW),
      .TIMEOUT (16)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .i_addr_valid   (i_addr_valid),
      .i_addr         (i_addr),
      .i_data_ready   (i_data_ready),
      .i_data         (i_data),
      .i_err          (i_err),
      .d_addr_valid   (d_addr_valid),
      .d_addr         (d_addr),
      .d_data_ready   (d_data_ready),
      .d_data         (d_data),
      .d_err          (d_err),
      .mem_addr_valid (mem_addr_valid),
      .mem_addr       (mem_addr),
      .mem_data_ready (mem_data_ready),
      .mem_data_i     (line_pat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave: answers after slave_wait stalled request cycles
   always @(posedge clk or negedge rst) begin
      if (!rst) waited <= 0;
      else if (mem_addr_valid && !mem_data_ready) waited <= waited + 1;
      else waited <= 0;
   end

   assign mem_data_ready = slave_on && mem_addr_valid && (waited >= slave_wait);

   task automatic apply_reset;
      rst = 1'b0;
      i_addr_valid = 1'b0;
      d_addr_valid = 1'b0;
      i_addr = '0;
      d_addr = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset;
      apply_reset();
      total_cnt++;
      if ({mem_addr_valid, i_data_ready, d_data_ready, i_err, d_err} !== 5'b0)
         $display("FAIL reset_ctrl: got %b exp 00000",
            {mem_addr_valid, i_data_ready, d_data_ready, i_err, d_err});
      else pass_cnt++;
      total_cnt++;
      if (mem_addr !== '0) $display("FAIL reset_addr: got %h exp 0", mem_addr);
      else pass_cnt++;
      total_cnt++;
      if ((i_data | d_data) !== '0) $display("FAIL reset_data: got nonzero exp 0");
      else pass_cnt++;
   endtask

   task automatic test_single_i;
      @(negedge clk);
      slave_on = 1'b1;
      slave_wait = 0;
      line_pat = {64{8'hA5}};
      i_addr = 32'h0000_0044;
      i_addr_valid = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (mem_addr_valid !== 1'b1 || mem_addr !== 32'h40)
         $display("FAIL single_req: got v=%b a=%h exp v=1 a=00000040", mem_addr_valid, mem_addr);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (i_data_ready !== 1'b1 || i_err !== 1'b0)
         $display("FAIL single_rdy: got rdy=%b err=%b exp 1 0", i_data_ready, i_err);
      else pass_cnt++;
      total_cnt++;
      if (i_data !== {64{8'hA5}}) $display("FAIL single_data: got %h exp a5..", i_data);
      else pass_cnt++;
      total_cnt++;
      if ({d_data_ready, d_err} !== 2'b0 || d_data !== '0)
         $display("FAIL single_d_quiet: got rdy=%b err=%b exp 0 0", d_data_ready, d_err);
      else pass_cnt++;
      i_addr_valid = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (i_data_ready !== 1'b0 || mem_addr_valid !== 1'b0)
         $display("FAIL single_pulse: got rdy=%b v=%b exp 0 0", i_data_ready, mem_addr_valid);
      else pass_cnt++;
   endtask

   task automatic test_conflict;
      apply_reset();
      line_pat = {64{8'h11}};
      i_addr = 32'h0000_0100;
      d_addr = 32'h0000_2000;
      i_addr_valid = 1'b1;
      d_addr_valid = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (mem_addr_valid !== 1'b1 || mem_addr !== 32'h100)
         $display("FAIL conflict_first: got v=%b a=%h exp v=1 a=00000100", mem_addr_valid, mem_addr);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({i_data_ready, d_data_ready} !== 2'b10 || i_data !== {64{8'h11}})
         $display("FAIL conflict_i_done: got rdy=%b%b exp 10", i_data_ready, d_data_ready);
      else pass_cnt++;
      i_addr_valid = 1'b0;
      line_pat = {64{8'h22}};
      @(negedge clk);
      total_cnt++;
      if ({mem_addr_valid, i_data_ready, d_data_ready} !== 3'b0)
         $display("FAIL conflict_gap: got %b exp 000", {mem_addr_valid, i_data_ready, d_data_ready});
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (mem_addr_valid !== 1'b1 || mem_addr !== 32'h2000)
         $display("FAIL conflict_second: got v=%b a=%h exp v=1 a=00002000", mem_addr_valid, mem_addr);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({i_data_ready, d_data_ready} !== 2'b01 || d_data !== {64{8'h22}})
         $display("FAIL conflict_d_done: got rdy=%b%b exp 01", i_data_ready, d_data_ready);
      else pass_cnt++;
      d_addr_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      logic          exp_i;
      logic [AW-1:0] exp_a;
      apply_reset();
      i_addr = 32'h0000_1234;
      d_addr = 32'h0000_2FFF;
      i_addr_valid = 1'b1;
      d_addr_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         exp_i = (k % 2 == 0);
         exp_a = exp_i ? 32'h1200 : 32'h2FC0;
         @(negedge clk);
         line_pat = {64{8'(k + 1)}};
         total_cnt++;
         if (mem_addr_valid !== 1'b1 || mem_addr !== exp_a)
            $display("FAIL rr_grant%0d: got v=%b a=%h exp v=1 a=%h", k, mem_addr_valid, mem_addr, exp_a);
         else pass_cnt++;
         @(negedge clk);
         total_cnt++;
         if ({i_data_ready, d_data_ready} !== {exp_i, !exp_i} ||
             (exp_i ? i_data : d_data) !== {64{8'(k + 1)}})
            $display("FAIL rr_done%0d: got rdy=%b%b exp %b%b", k,
               i_data_ready, d_data_ready, exp_i, !exp_i);
         else pass_cnt++;
         @(negedge clk);
         total_cnt++;
         if ({mem_addr_valid, i_data_ready, d_data_ready} !== 3'b0)
            $display("FAIL rr_turn%0d: got %b exp 000", k,
               {mem_addr_valid, i_data_ready, d_data_ready});
         else pass_cnt++;
      end
      i_addr_valid = 1'b0;
      d_addr_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_wait_states;
      slave_wait = 4;
      line_pat = {64{8'h3C}};
      d_addr = 32'h0000_5000;
      d_addr_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total_cnt++;
         if (mem_addr_valid !== 1'b1 || mem_addr !== 32'h5000 || d_data_ready !== 1'b0)
            $display("FAIL wait_hold%0d: got v=%b a=%h rdy=%b exp 1 00005000 0",
               c, mem_addr_valid, mem_addr, d_data_ready);
         else pass_cnt++;
      end
      @(negedge clk);
      total_cnt++;
      if (d_data_ready !== 1'b1 || d_err !== 1'b0 || d_data !== {64{8'h3C}})
         $display("FAIL wait_done: got rdy=%b err=%b exp 1 0", d_data_ready, d_err);
      else pass_cnt++;
      d_addr_valid = 1'b0;
      slave_wait = 0;
      @(negedge clk);
   endtask

   task automatic test_timeout;
      int n;
      slave_on = 1'b0;
      d_addr = 32'h0000_6000;
      d_addr_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (mem_addr_valid && n < 300) begin
         n++;
         @(negedge clk);
      end
      total_cnt++;
      if (n !== 16) $display("FAIL timeout_len: got %0d exp 16", n);
      else pass_cnt++;
      total_cnt++;
      if (d_data_ready !== 1'b1 || d_err !== 1'b1 || i_data_ready !== 1'b0)
         $display("FAIL timeout_err: got rdy=%b err=%b exp 1 1", d_data_ready, d_err);
      else pass_cnt++;
      total_cnt++;
      if (d_data !== '0) $display("FAIL timeout_data: got %h exp 0", d_data);
      else pass_cnt++;
      d_addr_valid = 1'b0;
      slave_on = 1'b1;
      line_pat = {64{8'h5A}};
      @(negedge clk);
      i_addr = 32'h0000_7000;
      i_addr_valid = 1'b1;
      repeat (2) @(negedge clk);
      total_cnt++;
      if (i_data_ready !== 1'b1 || i_err !== 1'b0 || i_data !== {64{8'h5A}})
         $display("FAIL timeout_recover: got rdy=%b err=%b exp 1 0", i_data_ready, i_err);
      else pass_cnt++;
      i_addr_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_timeout_edge;
      int n;
      slave_wait = 15;
      line_pat = {64{8'hC3}};
      d_addr = 32'h0000_9000;
      d_addr_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (mem_addr_valid && n < 300) begin
         n++;
         @(negedge clk);
      end
      total_cnt++;
      if (n !== 16) $display("FAIL edge_len: got %0d exp 16", n);
      else pass_cnt++;
      total_cnt++;
      if (d_data_ready !== 1'b1 || d_err !== 1'b0 || d_data !== {64{8'hC3}})
         $display("FAIL edge_data_wins: got rdy=%b err=%b exp 1 0", d_data_ready, d_err);
      else pass_cnt++;
      d_addr_valid = 1'b0;
      slave_wait = 0;
      @(negedge clk);
   endtask

   task automatic test_reset_in_req;
      slave_wait = 10;
      line_pat = {64{8'h69}};
      i_addr = 32'h0000_8040;
      i_addr_valid = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (mem_addr_valid !== 1'b1) $display("FAIL rreq_pre: got %b exp 1", mem_addr_valid);
      else pass_cnt++;
      #2 rst = 1'b0;
      #1;
      total_cnt++;
      if ({mem_addr_valid, i_data_ready, d_data_ready, i_err, d_err} !== 5'b0 || mem_addr !== '0)
         $display("FAIL rreq_async: got v=%b a=%h exp 0 0", mem_addr_valid, mem_addr);
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b1;
      slave_wait = 0;
      @(negedge clk);
      total_cnt++;
      if (mem_addr_valid !== 1'b1 || mem_addr !== 32'h8040)
         $display("FAIL rreq_regrant: got v=%b a=%h exp 1 00008040", mem_addr_valid, mem_addr);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (i_data_ready !== 1'b1 || i_err !== 1'b0 || i_data !== {64{8'h69}})
         $display("FAIL rreq_done: got rdy=%b err=%b exp 1 0", i_data_ready, i_err);
      else pass_cnt++;
      i_addr_valid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      pass_cnt = 0;
      total_cnt = 0;
      slave_on = 1'b1;
      slave_wait = 0;
      line_pat = '0;
      test_reset();
      test_single_i();
      test_conflict();
      test_back_to_back();
      test_wait_states();
      test_timeout();
      test_timeout_edge();
      test_reset_in_req();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
